// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide unit.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of the iterative multiplier / divider, purely combinational.
// Multiply: acc = {partial_product, remaining multiplier bits}, shift right.
// Divide:   acc = {partial_remainder, remaining dividend | quotient bits}, shift left.
module mips_cpu_muldiv_step
    import mips_cpu_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] diff;

    // Compute both the shift-add and the restoring-subtract candidates, pick one.
    always_comb begin
        // NOTE: default assignments first keep always_comb free of latches.
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        diff     = acc[63:31] - {1'b0, operand};
        acc_next = {sum, acc[31:1]};
        if (is_div) begin
            // A borrow means the trial subtraction failed: keep the shifted remainder.
            if (diff[32]) begin
                acc_next = {acc[62:0], 1'b0};
            end else begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit: 32-cycle iterative core, sign fix-up,
// and MTHI/MTLO moves accepted only while idle.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state;
    muldiv_op_t    op_q;
    logic [4:0]    cnt;
    logic [63:0]   acc;
    logic [63:0]   acc_next;
    logic [31:0]   operand;
    logic [31:0]   a_raw;
    logic          neg_res;
    logic          neg_rem;
    logic          b_zero;

    muldiv_op_t    op_in;
    logic          in_signed;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [63:0]   product;
    logic [31:0]   quotient;
    logic [31:0]   remainder;
    logic [31:0]   fix_hi;
    logic [31:0]   fix_lo;

    assign busy = (state != IDLE);

    mips_cpu_muldiv_step u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Operand magnitudes for the unsigned core, taken from the live inputs at start.
    always_comb begin
        op_in     = muldiv_op_t'(op);
        in_signed = op_is_signed(op_in);
        a_mag     = (in_signed && a[31]) ? (~a + 32'd1) : a;
        b_mag     = (in_signed && b[31]) ? (~b + 32'd1) : b;
    end

    // Sign fix-up and HI/LO selection applied at the FIX edge.
    always_comb begin
        product   = neg_res ? (~acc + 64'd1) : acc;
        quotient  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        remainder = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
        fix_hi    = product[63:32];
        fix_lo    = product[31:0];
        if (op_is_div(op_q)) begin
            if (b_zero) begin
                fix_hi = a_raw;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = remainder;
                fix_lo = quotient;
            end
        end
    end

    // FSM, iteration counter, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= MULT;
            cnt     <= 5'd0;
            acc     <= 64'd0;
            operand <= 32'd0;
            a_raw   <= 32'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CALC;
                        op_q    <= op_in;
                        cnt     <= 5'd0;
                        a_raw   <= a;
                        b_zero  <= (b == 32'd0);
                        neg_res <= in_signed && (a[31] ^ b[31]);
                        neg_rem <= in_signed && a[31];
                        if (op_is_div(op_in)) begin
                            acc     <= {32'd0, a_mag};
                            operand <= b_mag;
                        end else begin
                            acc     <= {32'd0, b_mag};
                            operand <= a_mag;
                        end
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(MULDIV_ITERS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv.
module tb_mips_cpu_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mips_cpu_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; start is sampled at the next rising edge (edge 0).
    // Walks cycles 1..34 checking busy/done timing and that HI/LO hold their old
    // values until the FIX edge. inj > 0 drives start+mthi+mtlo in that busy cycle.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj, input logic mv_lo);
        logic busy_bad = 1'b0;
        logic done_bad = 1'b0;
        logic hold_bad = 1'b0;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        mtlo  = mv_lo;
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (busy !== (k <= 33)) busy_bad = 1'b1;
            if (done !== (k == 34)) done_bad = 1'b1;
            if (k <= 33 && (hi !== exp_hi || lo !== exp_lo)) hold_bad = 1'b1;
            if (k == inj) begin
                start = 1'b1;
                mthi  = 1'b1;
                mtlo  = 1'b1;
                a     = 32'hDEAD_BEEF;
            end else if (k == inj + 1) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
        end
        check({tag, " busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, " done_pulse"},  32'(done_bad), 32'd0);
        check({tag, " hilo_hold"},   32'(hold_bad), 32'd0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    initial begin
        logic done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi",   hi, 32'd0);
        check("reset lo",   lo, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max x max, then MULT started in the done cycle.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);

        // Signed divide, divide by zero (unsigned and signed with negative dividend).
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("divu_zero", 2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 1'b0);

        // Overflow case, with start+mthi+mtlo thrown in during busy cycle 5.
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5, 1'b0);

        // Idle move of both registers at once.
        @(negedge clk);
        check("idle done_low", 32'(done), 32'd0);
        mthi = 1'b1;
        mtlo = 1'b1;
        a    = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo hi", hi, 32'h1234_5678);
        check("mthi_mtlo lo", lo, 32'h1234_5678);
        exp_hi = 32'h1234_5678;
        exp_lo = 32'h1234_5678;

        // start wins over a simultaneous mtlo: lo must not become 0x00010000.
        run_op("start_mtlo", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 1'b1);

        // Reset in cycle 10 of a MULTU aborts it.
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h0000_0003;
        b     = 32'h0000_0005;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi",   hi, 32'd0);
        check("abort lo",   lo, 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen = 1'b1;
        end
        check("abort no_done", 32'(done_seen), 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // A fresh operation after reset release completes normally.
        run_op("multu_after_rst", 2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
